// File: rtl/sm_pkg.sv
// Shared types and helpers for the signed-magnitude add/sub datapath.
// Holds the op encoding, the sign-bit offset and zero normalisation.
package sm_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } sm_op_e;

   localparam int SM_SIGN_LSB_OFFSET = 1;

   function automatic logic sm_norm(
      input logic sign,
      input logic mag_zero
   );
      return sign & ~mag_zero;
   endfunction

endpackage

// File: rtl/sm_pipe_stage.sv
// Generic valid/ready register slice with a combinational ready chain.
// Loads when empty or draining, otherwise holds valid and data.
module sm_pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [DW-1:0] up_data,
   output logic          dn_valid,
   input  logic          dn_ready,
   output logic [DW-1:0] dn_data
);

   logic adv;

   assign adv      = !dn_valid || dn_ready;
   assign up_ready = adv;

   // slice register: advance when free, hold while blocked downstream
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else if (adv) begin
         dn_valid <= up_valid;
         if (up_valid)
            dn_data <= up_data;
      end
   end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage signed-magnitude add/subtract with valid/ready handshakes.
// Overflow saturates when SM_ADD_SAT_EN is defined, otherwise wraps.
module sm_addsub_pipe
   import sm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  sm_op_e           in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int M  = WIDTH - 1;
   localparam int SB = WIDTH - SM_SIGN_LSB_OFFSET;

   typedef struct packed {
      logic             sa;
      logic [M-1:0]     ma;
      logic             sb;
      logic [M-1:0]     mb;
      logic [TAG_W-1:0] tag;
      logic             eq_sign;
      logic             a_ge_b;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             ovf;
      logic [TAG_W-1:0] tag;
   } s2_t;

   s1_t  s1_in;
   s1_t  s1_q;
   s2_t  s2_in;
   s2_t  s2_q;
   logic s1_valid;
   logic s2_adv;

   logic [M:0]   add_full;
   logic [M-1:0] diff;
   logic [M-1:0] mag;
   logic         sign;
   logic         ovf;

   // S1 input: fold op into b's sign, drop -0 signs, compare magnitudes
   always_comb begin
      s1_in         = '0;
      s1_in.ma      = in_a[M-1:0];
      s1_in.mb      = in_b[M-1:0];
      s1_in.sa      = sm_norm(in_a[SB], in_a[M-1:0] == '0);
      s1_in.sb      = sm_norm(in_b[SB] ^ (in_op == OP_SUB),
                              in_b[M-1:0] == '0);
      s1_in.tag     = in_tag;
      s1_in.eq_sign = (s1_in.sa == s1_in.sb);
      s1_in.a_ge_b  = (in_a[M-1:0] >= in_b[M-1:0]);
   end

   sm_pipe_stage #(
      .DW($bits(s1_t))
   ) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (in_valid),
      .up_ready (in_ready),
      .up_data  (s1_in),
      .dn_valid (s1_valid),
      .dn_ready (s2_adv),
      .dn_data  (s1_q)
   );

   // S2 input: add or larger-minus-smaller, then overflow handling
   always_comb begin
      add_full = {1'b0, s1_q.ma} + {1'b0, s1_q.mb};
      diff     = s1_q.a_ge_b ? (s1_q.ma - s1_q.mb)
                             : (s1_q.mb - s1_q.ma);
      ovf      = s1_q.eq_sign & add_full[M];
      sign     = (s1_q.eq_sign || s1_q.a_ge_b) ? s1_q.sa : s1_q.sb;
      mag      = s1_q.eq_sign ? add_full[M-1:0] : diff;
`ifdef SM_ADD_SAT_EN
      if (ovf)
         mag = '1;
`endif
      s2_in     = '0;
      s2_in.sum = {sm_norm(sign, mag == '0), mag};
      s2_in.ovf = ovf;
      s2_in.tag = s1_q.tag;
   end

   sm_pipe_stage #(
      .DW($bits(s2_t))
   ) u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (s1_valid),
      .up_ready (s2_adv),
      .up_data  (s2_in),
      .dn_valid (out_valid),
      .dn_ready (out_ready),
      .dn_data  (s2_q)
   );

   assign out_sum = s2_q.sum;
   assign out_ovf = s2_q.ovf;
   assign out_tag = s2_q.tag;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe: directed cases, stall,
// reset flush and throttled random traffic against an integer model.
module tb_sm_addsub_pipe;
   import sm_pkg::*;

   localparam int W  = 8;
   localparam int TW = 4;
   localparam int M  = W - 1;

`ifdef SM_ADD_SAT_EN
   localparam logic [W-1:0] T3A = 8'h7F;
   localparam logic [W-1:0] T3B = 8'hFF;
`else
   localparam logic [W-1:0] T3A = 8'h48;
   localparam logic [W-1:0] T3B = 8'hC8;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   sm_op_e        in_op = OP_ADD;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_sum;
   logic          out_ovf;
   logic [TW-1:0] out_tag;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int mode = 0;
   bit saw_block = 1'b0;

   typedef struct {
      logic [W-1:0]  sum;
      logic          ovf;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t q[$];

   sm_addsub_pipe #(
      .WIDTH (W),
      .TAG_W (TW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      nchk++;
      assert (got === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
      end
   endtask

   // signed integers in, signed-magnitude result out
   function automatic exp_t ref_calc(logic [W-1:0] a, logic [W-1:0] b,
                                     logic op, logic [TW-1:0] t);
      int   va, vb, r, mag, lim;
      exp_t e;
      lim = (1 << M) - 1;
      va  = int'(a[M-1:0]);
      vb  = int'(b[M-1:0]);
      if (a[M]) va = -va;
      if (b[M]) vb = -vb;
      r   = op ? (va - vb) : (va + vb);
      mag = (r < 0) ? -r : r;
      e.ovf = (mag > lim);
`ifdef SM_ADD_SAT_EN
      if (e.ovf) mag = lim;
`else
      mag = mag % (lim + 1);
`endif
      e.sum = {(r < 0) && (mag != 0), mag[M-1:0]};
      e.tag = t;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               chk("sum", 32'(out_sum), 32'(q[0].sum));
               chk("ovf", 32'(out_ovf), 32'(q[0].ovf));
               chk("tag", 32'(out_tag), 32'(q[0].tag));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready)
            q.push_back(ref_calc(in_a, in_b, in_op, in_tag));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
         1:       out_ready = ($urandom_range(0, 3) != 0);
         2:       out_ready = !(cyc >= 3 && cyc <= 5);
         3:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   endtask

   task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                       logic op, logic [TW-1:0] t);
      bit ok;
      ok       = 1'b0;
      in_a     = a;
      in_b     = b;
      in_op    = sm_op_e'(op);
      in_tag   = t;
      in_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
         if (!ok) saw_block = 1'b1;
         tick();
      end
      if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && q.size() != 0; k++) tick();
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic one(string nm, logic [W-1:0] a, logic [W-1:0] b,
                      logic op, logic [W-1:0] es, logic eo);
      send(a, b, op, 4'hA);
      chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      chk({nm, "_lat2"}, 32'(out_valid), 32'd1);
      chk({nm, "_sum"}, 32'(out_sum), 32'(es));
      chk({nm, "_ovf"}, 32'(out_ovf), 32'(eo));
      tick();
   endtask

   initial begin
      logic [W-1:0] a, b;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      tick();

      one("t1_add_mixed", 8'h05, 8'h83, 1'b0, 8'h02, 1'b0);
      one("t2_sub_neg", 8'h03, 8'h07, 1'b1, 8'h84, 1'b0);
      one("t2_cancel", 8'h85, 8'h05, 1'b0, 8'h00, 1'b0);
      one("t2_negzero", 8'h80, 8'h80, 1'b0, 8'h00, 1'b0);
      one("t3_pos_ovf", 8'h64, 8'h64, 1'b0, T3A, 1'b1);
      one("t3_neg_ovf", 8'hE4, 8'hE4, 1'b0, T3B, 1'b1);
      one("t3_wrap_zero", 8'h40, 8'h40, 1'b0,
`ifdef SM_ADD_SAT_EN
          8'h7F,
`else
          8'h00,
`endif
          1'b1);
      one("t3_sub_zero", 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);

      cyc       = 0;
      out_ready = 1'b1;
      mode      = 2;
      saw_block = 1'b0;
      for (int i = 0; i < 6; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         send(a, b, 1'($urandom), TW'(i));
      end
      mode = 0;
      drain();
      chk("t4_in_ready_drop", 32'(saw_block), 32'd1);

      mode      = 3;
      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0, 4'h1);
      send(8'h33, 8'h44, 1'b1, 4'h2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_out_sum", 32'(out_sum), 32'd0);
      chk("t5_out_ovf", 32'(out_ovf), 32'd0);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      mode      = 0;
      out_ready = 1'b1;
      repeat (8) tick();
      chk("t5_no_stale", 32'(out_valid), 32'd0);

      mode = 1;
      for (int i = 0; i < 400; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         if (($urandom & 7) == 0) a[M-1:0] = '0;
         if (($urandom & 7) == 1) b[M-1:0] = '1;
         if (($urandom & 3) == 0) tick();
         send(a, b, 1'($urandom), TW'($urandom));
      end
      mode = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
